// File: rtl/wstage_commit_pkg.sv
// Shared encodings for the write-back commit stage: FSM states, rdregsrc codes,
// machine-mode CSR addresses and the latched W-bus record.
package wstage_commit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_ECALL2  = 2'd2,
    ST_SEND_PC = 2'd3
  } state_e;

  localparam logic [2:0] RDSRC_NONE = 3'd0;
  localparam logic [2:0] RDSRC_ALU  = 3'd1;
  localparam logic [2:0] RDSRC_MEM  = 3'd2;
  localparam logic [2:0] RDSRC_SNPC = 3'd3;
  localparam logic [2:0] RDSRC_CSR  = 3'd4;
  localparam logic [2:0] RDSRC_CMP  = 3'd5;

  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  typedef struct packed {
    logic [31:0] dnpc;
    logic [31:0] mdata;
    logic [31:0] alu_result;
    logic [31:0] snpc;
    logic [31:0] pc;
    logic [31:0] csr;
    logic [31:0] src2;
    logic [2:0]  rdregsrc;
    logic [11:0] csraddr;
    logic [4:0]  rd;
    logic        cmp_result;
    logic        ecall;
  } wbus_t;

  // Codes 0, 6 and 7 carry no GPR result; x0 is never written.
  function automatic logic rd_writes(input logic [2:0] src, input logic [4:0] rd);
    return (src >= RDSRC_ALU) && (src <= RDSRC_CMP) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wstage_commit_wb_data_mux.sv
// GPR write-data select for the commit stage, steered by the rdregsrc code.
module wb_data_mux
  import wstage_commit_pkg::*;
(
  input  logic [2:0]  rdregsrc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] mdata_i,
  input  logic [31:0] snpc_i,
  input  logic [31:0] csr_i,
  input  logic        cmp_result_i,
  output logic [31:0] wdata_o
);

  always_comb begin
    wdata_o = 32'd0;
    case (rdregsrc_i)
      RDSRC_ALU:  wdata_o = alu_result_i;
      RDSRC_MEM:  wdata_o = mdata_i;
      RDSRC_SNPC: wdata_o = snpc_i;
      RDSRC_CSR:  wdata_o = csr_i;
      RDSRC_CMP:  wdata_o = {31'd0, cmp_result_i};
      default:    wdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/wstage_commit.sv
// Commit stage: latches a retiring instruction, performs GPR/CSR writes
// (two CSR cycles for ecall), then hands the next PC to the fetch unit.
module wstage_commit
  import wstage_commit_pkg::*;
#(
  parameter bit SINGLE_CYCLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dnpcW,
  input  logic [31:0] mdataW,
  input  logic [31:0] ALU_resultW,
  input  logic [31:0] snpcW,
  input  logic [31:0] pcW,
  input  logic [31:0] csrW,
  input  logic [31:0] src2W,
  input  logic [2:0]  rdregsrcW,
  input  logic [11:0] csraddrW,
  input  logic [4:0]  rdW,
  input  logic        cmp_resultW,
  input  logic        ecallW,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [31:0] npc,
  output logic        npc_valid,
  input  logic        npc_ready,
  output logic [63:0] retired
);

  state_e      state_q, state_d;
  wbus_t       wb_q, wb_d;
  logic [63:0] retired_q, retired_d;
  logic        ecall_pend_q, ecall_pend_d;

  wbus_t in_s;
  wbus_t cur_s;
  logic  wr_phase_s;
  logic  ec2_phase_s;
  logic  send_s;

  assign in_s = '{dnpc: dnpcW, mdata: mdataW, alu_result: ALU_resultW, snpc: snpcW,
                  pc: pcW, csr: csrW, src2: src2W, rdregsrc: rdregsrcW,
                  csraddr: csraddrW, rd: rdW, cmp_result: cmp_resultW, ecall: ecallW};

  // Pass-through mode works straight off the W-bus; only the mcause cycle is remembered.
  assign cur_s       = SINGLE_CYCLE ? in_s : wb_q;
  assign s_ready     = !rst && (SINGLE_CYCLE ? !ecall_pend_q : (state_q == ST_IDLE));
  assign wr_phase_s  = SINGLE_CYCLE ? (s_valid && s_ready) : (state_q == ST_WRITE);
  assign ec2_phase_s = SINGLE_CYCLE ? ecall_pend_q : (state_q == ST_ECALL2);
  assign send_s      = SINGLE_CYCLE ? wr_phase_s : (state_q == ST_SEND_PC);

  wb_data_mux u_wb_data_mux (
    .rdregsrc_i   (cur_s.rdregsrc),
    .alu_result_i (cur_s.alu_result),
    .mdata_i      (cur_s.mdata),
    .snpc_i       (cur_s.snpc),
    .csr_i        (cur_s.csr),
    .cmp_result_i (cur_s.cmp_result),
    .wdata_o      (rf_wdata)
  );

  assign rf_waddr  = cur_s.rd;
  assign npc       = send_s ? cur_s.dnpc : 32'd0;
  assign npc_valid = !rst && send_s;
  assign retired   = retired_q;

  // Write-port strobes; reset masks them so an aborted instruction writes nothing.
  always_comb begin
    rf_wen    = 1'b0;
    csr_wen   = 1'b0;
    csr_waddr = 12'd0;
    csr_wdata = 32'd0;
    if (rst) begin
      rf_wen  = 1'b0;
      csr_wen = 1'b0;
    end else if (ec2_phase_s) begin
      csr_wen   = 1'b1;
      csr_waddr = CSR_MCAUSE;
      csr_wdata = CAUSE_ECALL_M;
    end else if (wr_phase_s) begin
      rf_wen = rd_writes(cur_s.rdregsrc, cur_s.rd);
      if (cur_s.ecall) begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = cur_s.pc;
      end else if (cur_s.rdregsrc == RDSRC_CSR) begin
        csr_wen   = 1'b1;
        csr_waddr = cur_s.csraddr;
        csr_wdata = cur_s.alu_result;
      end else begin
        csr_wen = 1'b0;
      end
    end else begin
      rf_wen  = 1'b0;
      csr_wen = 1'b0;
    end
  end

  // Next-state, W-bus latch and retire counter.
  always_comb begin
    state_d      = state_q;
    wb_d         = wb_q;
    retired_d    = retired_q;
    ecall_pend_d = SINGLE_CYCLE && wr_phase_s && cur_s.ecall;
    if (npc_valid && npc_ready) begin
      retired_d = retired_q + 64'd1;
    end else begin
      retired_d = retired_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (!SINGLE_CYCLE && s_valid) begin
          wb_d    = in_s;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE:   state_d = wb_q.ecall ? ST_ECALL2 : ST_SEND_PC;
      ST_ECALL2:  state_d = ST_SEND_PC;
      ST_SEND_PC: state_d = npc_ready ? ST_IDLE : ST_SEND_PC;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wb_q         <= '0;
      retired_q    <= 64'd0;
      ecall_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_q         <= wb_d;
      retired_q    <= retired_d;
      ecall_pend_q <= ecall_pend_d;
    end
  end

endmodule

// File: tb/tb_wstage_commit.sv
// Directed + randomized bench for wstage_commit; each instruction's expected
// writes, npc and retire count come from a per-instruction model of the rules.
module tb_wstage_commit;

  typedef struct {
    logic [31:0] dnpc, mdata, alu, snpc, pc, csr, src2;
    logic [2:0]  src;
    logic [11:0] caddr;
    logic [4:0]  rd;
    logic        cmp, ecall;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dnpcW, mdataW, ALU_resultW, snpcW, pcW, csrW, src2W;
  logic [2:0]  rdregsrcW;
  logic [11:0] csraddrW;
  logic [4:0]  rdW;
  logic        cmp_resultW, ecallW, s_valid, npc_ready;
  logic        s_ready, rf_wen, csr_wen, npc_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wdata, npc;
  logic [11:0] csr_waddr;
  logic [63:0] retired;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [63:0] ret_model = 64'd0;

  always #5 clk = ~clk;

  wstage_commit dut (
    .clk(clk), .rst(rst), .dnpcW(dnpcW), .mdataW(mdataW), .ALU_resultW(ALU_resultW),
    .snpcW(snpcW), .pcW(pcW), .csrW(csrW), .src2W(src2W), .rdregsrcW(rdregsrcW),
    .csraddrW(csraddrW), .rdW(rdW), .cmp_resultW(cmp_resultW), .ecallW(ecallW),
    .s_valid(s_valid), .s_ready(s_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .npc(npc), .npc_valid(npc_valid), .npc_ready(npc_ready), .retired(retired)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    i.dnpc = $urandom; i.mdata = $urandom; i.alu = $urandom; i.snpc = $urandom;
    i.pc = $urandom; i.csr = $urandom; i.src2 = $urandom;
    i.src = 3'($urandom_range(0, 7));
    i.caddr = 12'($urandom); i.rd = 5'($urandom); i.cmp = 1'($urandom);
    i.ecall = ($urandom_range(0, 4) == 0);
    if (i.ecall) i.src = 3'd0;
    return i;
  endfunction

  task automatic drive_bus(input ins_t i);
    dnpcW = i.dnpc; mdataW = i.mdata; ALU_resultW = i.alu; snpcW = i.snpc; pcW = i.pc;
    csrW = i.csr; src2W = i.src2; rdregsrcW = i.src; csraddrW = i.caddr; rdW = i.rd;
    cmp_resultW = i.cmp; ecallW = i.ecall;
  endtask

  // Reference: what the GPR should receive for an instruction.
  function automatic logic [31:0] exp_gpr(input ins_t i);
    case (i.src)
      3'd1: return i.alu;
      3'd2: return i.mdata;
      3'd3: return i.snpc;
      3'd4: return i.csr;
      3'd5: return {31'd0, i.cmp};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit exp_gpr_wr(input ins_t i);
    return (i.src >= 3'd1) && (i.src <= 3'd5) && (i.rd != 5'd0);
  endfunction

  // Issue one instruction from IDLE and follow it through every stage cycle.
  task automatic issue(input ins_t i, input int stall);
    logic [43:0] cq[$];
    int nw;
    if (i.ecall) begin
      cq.push_back({12'h341, i.pc});
      cq.push_back({12'h342, 32'd11});
    end else if (i.src == 3'd4) begin
      cq.push_back({i.caddr, i.alu});
    end
    nw = i.ecall ? 2 : 1;
    drive_bus(i); s_valid = 1'b1; npc_ready = 1'b1;
    check("s_ready_idle", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0; drive_bus(rand_ins());
    for (int k = 0; k < nw; k++) begin
      check("rf_wen", rf_wen, (k == 0) && exp_gpr_wr(i));
      if ((k == 0) && exp_gpr_wr(i)) begin
        check("rf_waddr", rf_waddr, i.rd);
        check("rf_wdata", rf_wdata, exp_gpr(i));
      end
      check("csr_wen", csr_wen, k < cq.size());
      if (k < cq.size()) begin
        check("csr_waddr", csr_waddr, cq[k][43:32]);
        check("csr_wdata", csr_wdata, cq[k][31:0]);
      end
      check("npc_valid_early", npc_valid, 0);
      check("s_ready_busy", s_ready, 0);
      @(negedge clk);
    end
    for (int k = 0; k <= stall; k++) begin
      npc_ready = (k == stall);
      check("npc_valid", npc_valid, 1);
      check("npc", npc, i.dnpc);
      check("s_ready_send", s_ready, 0);
      check("retired_hold", retired, ret_model);
      check("rf_wen_send", rf_wen, 0);
      check("csr_wen_send", csr_wen, 0);
      if (k < stall) begin
        drive_bus(rand_ins()); s_valid = 1'($urandom);
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
    npc_ready = 1'b0;
    ret_model = ret_model + 64'd1;
    check("retired", retired, ret_model);
    check("s_ready_back", s_ready, 1);
    check("npc_valid_after", npc_valid, 0);
  endtask

  initial begin
    ins_t i;
    ins_t bl[$];
    logic [36:0] eq[$];
    int cyc, last_acc, idx, writes;

    rst = 1'b1; s_valid = 1'b0; npc_ready = 1'b0;
    i = rand_ins(); drive_bus(i);
    repeat (3) @(negedge clk);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_csr_wen", csr_wen, 0);
    check("rst_npc_valid", npc_valid, 0);
    check("rst_retired", retired, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);

    // Plain ALU result to x5.
    i = rand_ins(); i.ecall = 1'b0; i.src = 3'd1; i.rd = 5'd5; i.alu = 32'h1234;
    issue(i, 0);
    // CSR write with rd=x0.
    i = rand_ins(); i.ecall = 1'b0; i.src = 3'd4; i.rd = 5'd0; i.caddr = 12'h300;
    i.csr = 32'hA; i.alu = 32'hB;
    issue(i, 0);
    // ecall: mepc then mcause.
    i = rand_ins(); i.ecall = 1'b1; i.src = 3'd0; i.pc = 32'h8000_0010; i.dnpc = 32'h8000_0100;
    issue(i, 0);
    // Fetch unit stalls for 5 cycles.
    i = rand_ins(); i.ecall = 1'b0; i.src = 3'd3; i.rd = 5'd7;
    issue(i, 5);
    // cmp result, then the unused codes 6/7.
    i = rand_ins(); i.ecall = 1'b0; i.src = 3'd5; i.rd = 5'd31;
    issue(i, 1);
    i = rand_ins(); i.ecall = 1'b0; i.src = 3'd6; i.rd = 5'd9;
    issue(i, 0);

    for (int n = 0; n < 25; n++) issue(rand_ins(), $urandom_range(0, 3));

    // Back-to-back stream with s_valid held high.
    for (int n = 0; n < 6; n++) begin
      i = rand_ins(); i.ecall = 1'b0; i.src = 3'd1; i.rd = 5'(n + 1);
      bl.push_back(i);
    end
    s_valid = 1'b1; npc_ready = 1'b1; drive_bus(bl[0]);
    cyc = 0; last_acc = -1; idx = 0; writes = 0;
    while (writes < 6 && cyc < 60) begin
      if (rf_wen) begin
        check("b2b_write_expected", eq.size() > 0, 1);
        if (eq.size() > 0) begin
          check("b2b_rd", rf_waddr, eq[0][36:32]);
          check("b2b_data", rf_wdata, eq[0][31:0]);
          void'(eq.pop_front());
        end
        writes++;
      end
      if (s_ready && idx < 6) begin
        if (last_acc >= 0) check("b2b_interval", cyc - last_acc, 3);
        last_acc = cyc;
        eq.push_back({bl[idx].rd, bl[idx].alu});
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (idx < 6) drive_bus(bl[idx]);
      else s_valid = 1'b0;
    end
    check("b2b_writes", writes, 6);
    @(negedge clk);
    ret_model = ret_model + 64'd6;
    check("b2b_retired", retired, ret_model);
    check("b2b_s_ready", s_ready, 1);
    npc_ready = 1'b0;

    // Reset while the mcause write is pending.
    i = rand_ins(); i.ecall = 1'b1; i.src = 3'd0;
    drive_bus(i); s_valid = 1'b1; npc_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("rst_mepc_wen", csr_wen, 1);
    check("rst_mepc_addr", csr_waddr, 12'h341);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_no_mcause", csr_wen, 0);
    check("rst_no_rf", rf_wen, 0);
    @(negedge clk);
    check("rst_mid_retired", retired, 0);
    check("rst_mid_npc_valid", npc_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    ret_model = 64'd0;
    check("rst_mid_s_ready", s_ready, 1);
    check("rst_mid_csr_wen", csr_wen, 0);
    check("rst_mid_npc_valid2", npc_valid, 0);
    npc_ready = 1'b0;

    i = rand_ins(); i.ecall = 1'b0; i.src = 3'd2; i.rd = 5'd12;
    issue(i, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
